// File: rtl/fas_frame_sched.sv
// rtl/fas_frame_sched.sv - ping-pong frame scheduler between the FIR stream and the FFT/analysis datapath
//
// Collects FIR samples into FRAME_LEN-sample frames in two banks, starts the
// FFT (and, when FAS_ANA_EN is defined, the analysis stage) on each full bank,
// then retires the bank, counts frames and flags overrun / completion.
//
// Optional feature macro: FAS_ANA_EN
//   defined   : IDLE -> FFT_RUN -> ANA_RUN -> retire
//   undefined : ana_start tied to 0, ana_done unused, fft_done retires directly
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   fir_valid, fir_d       input sample stream (8.8 fixed point)
//   wr_en, wr_bank,
//   wr_addr, wr_data       registered buffer write port
//   fft_start, fft_bank    FFT start pulse and bank it reads
//   fft_done               FFT completion pulse
//   ana_start, ana_done    analysis start / completion pulses
//   frame_cnt              retired frame count
//   overrun                sticky: a sample was dropped
//   all_done               sticky: NUM_FRAMES frames retired
module fas_frame_sched #(
   parameter int FRAME_LEN   = 16,
   parameter int NUM_FRAMES  = 64,
   parameter int FRAME_CNT_W = 7
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fir_valid,
   input  logic [15:0]                  fir_d,
   output logic                         wr_en,
   output logic                         wr_bank,
   output logic [$clog2(FRAME_LEN)-1:0] wr_addr,
   output logic [15:0]                  wr_data,
   output logic                         fft_start,
   output logic                         fft_bank,
   input  logic                         fft_done,
   output logic                         ana_start,
   input  logic                         ana_done,
   output logic [FRAME_CNT_W-1:0]       frame_cnt,
   output logic                         overrun,
   output logic                         all_done
);

   localparam int AW = $clog2(FRAME_LEN);
   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
   localparam logic [FRAME_CNT_W-1:0] CNT_END = FRAME_CNT_W'(NUM_FRAMES);

   typedef enum logic [1:0] {IDLE, FFT_RUN, ANA_RUN} state_t;

   state_t                 state, state_nxt;
   logic                   wbank, rbank;
   logic [AW-1:0]          waddr;
   logic [1:0]             full, full_nxt;
   logic                   accept, drop;
   logic                   start_nxt, retire;
   logic [FRAME_CNT_W-1:0] cnt_inc;

   // ---------------- consumer FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- consumer FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (full[rbank] && !all_done) state_nxt = FFT_RUN;
`ifdef FAS_ANA_EN
         FFT_RUN: if (fft_done) state_nxt = ANA_RUN;
         ANA_RUN: if (ana_done) state_nxt = IDLE;
`else
         FFT_RUN: if (fft_done) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- consumer FSM: outputs ----------------
`ifdef FAS_ANA_EN
   logic ana_nxt;
   always_comb begin
      start_nxt = (state == IDLE) && full[rbank] && !all_done;
      ana_nxt   = (state == FFT_RUN) && fft_done;
      retire    = (state == ANA_RUN) && ana_done;
   end

   always_ff @(posedge clk) begin
      if (rst) ana_start <= 1'b0;
      else     ana_start <= ana_nxt;
   end
`else
   logic unused_ana_done;
   assign unused_ana_done = ana_done;
   assign ana_start       = 1'b0;

   always_comb begin
      start_nxt = (state == IDLE) && full[rbank] && !all_done;
      retire    = (state == FFT_RUN) && fft_done;
   end
`endif

   // ---------------- producer side ----------------
   // A retire clearing the bank being written frees it on the same edge, so
   // a sample arriving then is accepted rather than dropped.
   always_comb begin
      accept   = fir_valid && !all_done &&
                 (!full[wbank] || (retire && (rbank == wbank)));
      drop     = fir_valid && !all_done && !accept;
      cnt_inc  = frame_cnt + 1'b1;
      full_nxt = full;
      if (retire) full_nxt[rbank] = 1'b0;
      if (accept && (waddr == LAST_ADDR)) full_nxt[wbank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wbank     <= 1'b0;
         waddr     <= '0;
         full      <= 2'b00;
         rbank     <= 1'b0;
         wr_en     <= 1'b0;
         wr_bank   <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         fft_start <= 1'b0;
         fft_bank  <= 1'b0;
         frame_cnt <= '0;
         overrun   <= 1'b0;
         all_done  <= 1'b0;
      end else begin
         wr_en     <= accept;
         fft_start <= start_nxt;
         full      <= full_nxt;
         if (accept) begin
            wr_bank <= wbank;
            wr_addr <= waddr;
            wr_data <= fir_d;
            if (waddr == LAST_ADDR) begin
               waddr <= '0;
               wbank <= ~wbank;
            end else begin
               waddr <= waddr + 1'b1;
            end
         end
         if (drop) overrun <= 1'b1;
         // fft_bank latches at start and holds until the frame retires
         if (start_nxt) fft_bank <= rbank;
         if (retire) begin
            rbank     <= ~rbank;
            frame_cnt <= cnt_inc;
            if (cnt_inc == CNT_END) all_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fas_frame_sched.sv
// tb/tb_fas_frame_sched.sv - scoreboard testbench for fas_frame_sched
module tb_fas_frame_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        fir_valid;
   logic [15:0] fir_d;
   logic        wr_en;
   logic        wr_bank;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        fft_start;
   logic        fft_bank;
   logic        fft_done;
   logic        ana_start;
   logic        ana_done;
   logic [6:0]  frame_cnt;
   logic        overrun;
   logic        all_done;

   fas_frame_sched #(.FRAME_LEN(16), .NUM_FRAMES(64), .FRAME_CNT_W(7)) dut (
      .clk(clk), .rst(rst),
      .fir_valid(fir_valid), .fir_d(fir_d),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
      .ana_start(ana_start), .ana_done(ana_done),
      .frame_cnt(frame_cnt), .overrun(overrun), .all_done(all_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic        b;
      logic [3:0]  a;
      logic [15:0] d;
   } wr_t;

   typedef struct {
      int   cyc;
      logic b;
   } st_t;

   wr_t wr_q[$];
   st_t fft_q[$];
   int  ana_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      wr_t e;
      st_t s;
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
         check("wr_missing", cyc, wr_q[0].cyc);
         void'(wr_q.pop_front());
      end
      while (fft_q.size() > 0 && fft_q[0].cyc < cyc) begin
         check("fft_start_missing", cyc, fft_q[0].cyc);
         void'(fft_q.pop_front());
      end
      while (ana_q.size() > 0 && ana_q[0] < cyc) begin
         check("ana_start_missing", cyc, ana_q[0]);
         void'(ana_q.pop_front());
      end
      if (wr_en) begin
         if (wr_q.size() == 0) check("wr_unexpected", int'(wr_en), 0);
         else begin
            e = wr_q.pop_front();
            check("wr_cycle", cyc, e.cyc);
            check("wr_bank_addr_data", int'({wr_bank, wr_addr, wr_data}), int'({e.b, e.a, e.d}));
         end
      end
      if (fft_start) begin
         if (fft_q.size() == 0) check("fft_start_unexpected", int'(fft_start), 0);
         else begin
            s = fft_q.pop_front();
            check("fft_start_cycle", cyc, s.cyc);
            check("fft_bank", int'(fft_bank), int'(s.b));
         end
      end
      if (ana_start) begin
         if (ana_q.size() == 0) check("ana_start_unexpected", int'(ana_start), 0);
         else check("ana_start_cycle", cyc, ana_q.pop_front());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input bit acc, input logic b, input logic [3:0] a);
      fir_valid = 1'b1;
      fir_d     = d;
      if (acc) wr_q.push_back(wr_t'{cyc + 1, b, a, d});
      tick();
   endtask

   task automatic expect_fft(input int at, input logic b);
      fft_q.push_back(st_t'{at, b});
   endtask

   // Leaves the retiring done pulse asserted in the current cycle; the
   // caller may add a sample and then calls release_retire.
   task automatic arm_retire(input int fd_delay, input int ad_delay);
      repeat (fd_delay) tick();
`ifdef FAS_ANA_EN
      fft_done = 1'b1;
      ana_q.push_back(cyc + 1);
      tick();
      fft_done = 1'b0;
      repeat (ad_delay) tick();
      ana_done = 1'b1;
`else
      if (ad_delay < 0) ana_done = 1'b0;
      fft_done = 1'b1;
`endif
   endtask

   task automatic release_retire();
      tick();
      fft_done  = 1'b0;
      ana_done  = 1'b0;
      fir_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, int'(wr_en), 0);
      check({tag, "_fft_start"}, int'(fft_start), 0);
      check({tag, "_fft_bank"}, int'(fft_bank), 0);
      check({tag, "_ana_start"}, int'(ana_start), 0);
      check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
      check({tag, "_all_done"}, int'(all_done), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int r;
      rst = 1'b1; fir_valid = 1'b1; fir_d = 16'h0055; fft_done = 1'b1; ana_done = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
      rst = 1'b0;
      tick();

      // Frame 0: samples 0x0001..0x0010 into bank 0
      for (int i = 0; i < 16; i++) begin
         if (i == 15) expect_fft(cyc + 2, 1'b0);
         send(16'(i + 1), 1'b1, 1'b0, 4'(i));
      end
      fir_valid = 1'b0;
      tick();
      arm_retire(20, 5);
      release_retire();
      check("frame_cnt_1", int'(frame_cnt), 1);
      tick();

      // Continuous stream: bank 1 then bank 0 fill, sample 33 dropped
      for (int i = 0; i < 33; i++) begin
         if (i == 15) expect_fft(cyc + 2, 1'b1);
         if (i < 32) send(16'h0100 + 16'(i), 1'b1, (i < 16) ? 1'b1 : 1'b0, 4'(i % 16));
         else        send(16'h0100 + 16'(i), 1'b0, 1'b0, 4'd0);
      end
      fir_valid = 1'b0;
      check("overrun_set", int'(overrun), 1);
      // fft_start was at (cycle now - 16); withhold fft_done 40 cycles total
      arm_retire(24, 2);
      // sample on the retire edge targets bank 1 and is accepted at addr 0
      r = cyc;
      fir_valid = 1'b1; fir_d = 16'h0BEE;
      wr_q.push_back(wr_t'{r + 1, 1'b1, 4'd0, 16'h0BEE});
      expect_fft(r + 2, 1'b0);
      release_retire();
      check("frame_cnt_2", int'(frame_cnt), 2);
      repeat (3) tick();

      // Reset while in FFT_RUN, then late done pulses are ignored
      rst = 1'b1;
      repeat (2) tick();
      check_all_zero("midreset");
      rst = 1'b0;
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0; ana_done = 1'b1;
      tick();
      ana_done = 1'b0;
      repeat (5) tick();
      check("postreset_frame_cnt", int'(frame_cnt), 0);

      // Retire and write to the same bank on one edge, both banks full
      for (int i = 0; i < 32; i++) begin
         if (i == 15) expect_fft(cyc + 2, 1'b0);
         send(16'h0200 + 16'(i), 1'b1, (i < 16) ? 1'b0 : 1'b1, 4'(i % 16));
      end
      fir_valid = 1'b0;
      arm_retire(0, 1);
      r = cyc;
      fir_valid = 1'b1; fir_d = 16'h0CAF;
      wr_q.push_back(wr_t'{r + 1, 1'b0, 4'd0, 16'h0CAF});
      expect_fft(r + 2, 1'b1);
      release_retire();
      check("simul_overrun", int'(overrun), 0);
      tick();
      arm_retire(0, 0);
      release_retire();
      check("simul_frame_cnt", int'(frame_cnt), 2);

      // 64 frames with instant done responses
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int f = 0; f < 64; f++) begin
         for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_fft(cyc + 2, 1'(f % 2));
            send(16'(f * 16 + i), 1'b1, 1'(f % 2), 4'(i));
         end
         fir_valid = 1'b0;
         tick();
         arm_retire(0, 0);
         release_retire();
         if (f == 62) check("frame_cnt_63_all_done", int'(all_done), 0);
      end
      check("all_done", int'(all_done), 1);
      check("frame_cnt_64", int'(frame_cnt), 64);
      for (int i = 0; i < 20; i++) send(16'hFFFF, 1'b0, 1'b0, 4'd0);
      fir_valid = 1'b0;
      fft_done = 1'b1; ana_done = 1'b1;
      repeat (3) tick();
      fft_done = 1'b0; ana_done = 1'b0;
      repeat (3) tick();
      check("after_done_overrun", int'(overrun), 0);
      check("after_done_frame_cnt", int'(frame_cnt), 64);

      check("wr_q_left", wr_q.size(), 0);
      check("fft_q_left", fft_q.size(), 0);
      check("ana_q_left", ana_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fas_frame_sched.md
# fas_frame_sched

Frame scheduler between the FIR filter and the shared 16-point FFT/analysis datapath of the FAS design. Collects the FIR output stream into 16-sample frames in a two-bank (ping-pong) sample buffer. Starts the FFT on each completed bank, then the frequency analysis stage. Retires the bank for reuse, counts frames, and flags overrun and completion.

## Interface
- `FRAME_LEN`, 16: samples per frame; a power of two ≥ 2.
- `NUM_FRAMES`, 64: frames to process before `all_done`.
- `FRAME_CNT_W`, 7: width of `frame_cnt`; must hold `NUM_FRAMES`.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `fir_valid`  in  1: `fir_d` carries a sample this cycle.
- `fir_d`  in  16: FIR sample, 8.8 fixed point, passed through unmodified.
- `wr_en`  out  1: buffer write strobe.
- `wr_bank`  out  1: bank being written.
- `wr_addr`  out  log2(`FRAME_LEN`): slot within the bank.
- `wr_data`  out  16: registered copy of `fir_d`.
- `fft_start`  out  1: one-cycle pulse that starts the FFT.
- `fft_bank`  out  1: bank the FFT reads. Stable from the `fft_start` cycle until the frame retires.
- `fft_done`  in  1: FFT finished; one-cycle pulse.
- `ana_start`  out  1: one-cycle pulse that starts the analysis stage.
- `ana_done`  in  1: analysis finished; one-cycle pulse.
- `frame_cnt`  out  `FRAME_CNT_W`: number of retired frames.
- `overrun`  out  1: sticky; a sample was dropped.
- `all_done`  out  1: sticky; `NUM_FRAMES` frames have retired.

## Operation
- Producer side:
  - State is `wbank`, `waddr`, and `full[1:0]`.
  - A sample is accepted when `fir_valid` is high, `full[wbank]` is clear and `all_done` is low.
  - An accepted sample is written to (`wbank`, `waddr`); `waddr` then increments.
  - When `waddr` is `FRAME_LEN-1`, the write sets `full[wbank]`, toggles `wbank` and wraps `waddr` to 0.
- Overrun:
  - `fir_valid` while `full[wbank]` is set: the sample is dropped and `overrun` is set.
  - `waddr` and `wbank` are unchanged.
- Consumer FSM:
  - State `rbank` starts at 0. States are IDLE, FFT_RUN and ANA_RUN.
  - IDLE: if `full[rbank]` is set and `all_done` is low, pulse `fft_start` and go to FFT_RUN; `fft_bank` = `rbank`.
  - FFT_RUN: on `fft_done`, pulse `ana_start` and go to ANA_RUN.
  - ANA_RUN: on `ana_done`, retire the frame and return to IDLE.
  - Retire means: clear `full[rbank]`, toggle `rbank`, increment `frame_cnt`. If the new count equals `NUM_FRAMES`, set `all_done`.
  - `fft_done` outside FFT_RUN is ignored. `ana_done` outside ANA_RUN is ignored.
- After `all_done`:
  - All samples are ignored; `overrun` is not set.
  - No further start pulses are issued.
  - `frame_cnt` holds.
- Reset:
  - All outputs go to 0: `wr_*`, `fft_start`, `fft_bank`, `ana_start`, `frame_cnt`, `overrun`, `all_done`.
  - `full`, `wbank`, `waddr` and `rbank` clear; the FSM goes to IDLE.
  - Reset mid-frame discards any partial or pending frame. A `fft_done` or `ana_done` arriving after reset is ignored.

## Timing
- All outputs are registered.
- Write path: a sample accepted at edge E drives `wr_en`, `wr_bank`, `wr_addr` and `wr_data` in the cycle after E. Throughput is one sample per clock, with no bubbles.
- FFT start: the last sample of a frame is accepted at E, which sets `full` at E. `fft_start` is high in the cycle after edge E+1, i.e. one cycle after the last `wr_en`.
- Handshake latency: `fft_done` sampled at edge F gives `ana_start` high in the cycle after F. The `ana_done` → retire path has the same one-edge latency.
- Retire and restart: a retire at edge R makes the other bank eligible at edge R+1. There is at most one idle cycle between `ana_done` and the next `fft_start`.
- Simultaneous retire and write to the same bank: the clear takes priority. A sample arriving at the same edge that retire clears `full[wbank]` is accepted, not dropped.
- Simultaneous last write and start check: `full` is read registered, so a bank that fills at edge E is first seen by IDLE at E+1.

## Configuration
- `FAS_ANA_EN` defined:
  - Full flow IDLE → FFT_RUN → ANA_RUN → retire.
- `FAS_ANA_EN` undefined:
  - ANA_RUN is removed and `ana_start` is tied to 0.
  - `ana_done` is unused.
  - `fft_done` in FFT_RUN retires the frame directly.

## Test plan
- Reset, then 16 consecutive samples 0x0001–0x0010:
  - `wr_addr` runs 0–15 on bank 0 with `wr_data` matching.
  - `fft_start` fires 1 cycle after the 16th `wr_en`, with `fft_bank`=0.
- `fft_done` 20 cycles after start, then `ana_done` 5 cycles after `ana_start`:
  - `ana_start` is 1 cycle after `fft_done`.
  - `frame_cnt`=1 one cycle after `ana_done`.
  - The next frame starts with `fft_bank`=1.
- Continuous stream, with `fft_done` withheld for 40 cycles:
  - Banks 0 and 1 fill.
  - Sample 33 is dropped: `overrun`=1, `wr_en` stays low, `waddr` stays 0.
- `ana_done` on the same edge as a sample targeting the retiring bank:
  - The sample is accepted at `wr_addr`=0; `overrun` stays 0.
- 64 frames with instant done responses:
  - `all_done`=1 with `frame_cnt`=64.
  - Further `fir_valid` causes no `wr_en` and no `overrun`.
- Assert `rst` while in FFT_RUN, then pulse `fft_done`:
  - Everything reads 0 and no `ana_start` is issued.
  - Under `FAS_ANA_EN` undefined, the run completes with `ana_start` never asserted.
